// File: rtl/shift_arb.sv
`default_nettype none
// ============================================================================
// Module   : shift_arb
// Purpose  : Round-robin arbiter that shares one 32-bit barrel shifter
//            (SLL/SRL/SRA) among NUM_REQ valid/ready requesters. The result
//            goes to a single registered response channel that carries an ID tag.
// Revision : 1.0 - initial release
// ============================================================================
module shift_arb #(
  parameter int NUM_REQ = 2,
  parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [32*NUM_REQ-1:0]   req_data_i,
  input  logic [5*NUM_REQ-1:0]    req_shamt_i,
  input  logic [2*NUM_REQ-1:0]    req_op_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [IDW-1:0]          rsp_id_o,
  output logic [31:0]             rsp_data_o,
  output logic                    rsp_err_o
);

  localparam logic [1:0]   OP_SLL  = 2'b00;
  localparam logic [1:0]   OP_SRL  = 2'b01;
  localparam logic [1:0]   OP_SRA  = 2'b10;
  localparam logic [IDW:0] NUM_EXT = (IDW+1)'(NUM_REQ);

  logic           can_accept;
  logic           any_valid;
  logic           accept;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] grant;
  logic [IDW:0]   scan_sum;
  logic [IDW-1:0] scan_idx;
  logic [31:0]    sel_data;
  logic [4:0]     sel_shamt;
  logic [1:0]     sel_op;
  logic [31:0]    shift_res;
  logic           shift_err;

  // The response slot is free when empty or being drained this cycle.
  assign can_accept = !rsp_valid_o || rsp_ready_i;
  assign any_valid  = |req_valid_i;
  assign accept     = any_valid && can_accept;

  // Round-robin scan: first valid requester at or after ptr, wrapping.
  always_comb begin
    grant    = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      scan_sum = {1'b0, ptr} + (IDW+1)'(i);
      if (scan_sum >= NUM_EXT) begin
        scan_idx = IDW'(scan_sum - NUM_EXT);
      end else begin
        scan_idx = IDW'(scan_sum);
      end
      // Descending offset order, so the smallest offset wins last.
      if (req_valid_i[scan_idx]) begin
        grant = scan_idx;
      end
    end
  end

  // One-hot ready to the granted requester; held low while in reset.
  assign req_ready_o = (accept && rst_ni) ? (NUM_REQ'(1) << grant) : '0;

  // Route the granted requester's operands to the shared shifter.
  always_comb begin
    sel_data  = '0;
    sel_shamt = '0;
    sel_op    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant == IDW'(k)) begin
        sel_data  = req_data_i[32*k +: 32];
        sel_shamt = req_shamt_i[5*k +: 5];
        sel_op    = req_op_i[2*k +: 2];
      end
    end
  end

  // Shared barrel shifter; the illegal op yields zero with the error flag.
  always_comb begin
    shift_res = '0;
    shift_err = 1'b0;
    case (sel_op)
      OP_SLL:  shift_res = sel_data << sel_shamt;
      OP_SRL:  shift_res = sel_data >> sel_shamt;
      OP_SRA:  shift_res = 32'($signed(sel_data) >>> sel_shamt);
      default: shift_err = 1'b1;
    endcase
  end

  // Response valid: set on accept, cleared on a drain with no new accept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_o <= 1'b0;
    end else if (accept) begin
      rsp_valid_o <= 1'b1;
    end else if (rsp_ready_i) begin
      rsp_valid_o <= 1'b0;
    end
  end

  // Response payload loads only on accept, so it holds under backpressure.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_id_o   <= '0;
      rsp_data_o <= '0;
      rsp_err_o  <= 1'b0;
    end else if (accept) begin
      rsp_id_o   <= grant;
      rsp_data_o <= shift_res;
      rsp_err_o  <= shift_err;
    end
  end

  generate
    if (NUM_REQ == 1) begin : g_ptr_single
      // A single requester needs no rotation.
      assign ptr = '0;
    end else begin : g_ptr_rr
      logic [IDW:0] ptr_sum;
      assign ptr_sum = {1'b0, grant} + (IDW+1)'(1);

      // Pointer moves just past the winner on every accept.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          ptr <= '0;
        end else if (accept) begin
          ptr <= (ptr_sum >= NUM_EXT) ? '0 : IDW'(ptr_sum);
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_shift_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_arb
// Purpose  : Directed and random checks of shift_arb (NUM_REQ=2) against a
//            behavioural model of arbitration and shift arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_arb;

  localparam int N   = 2;
  localparam int IDW = 1;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic [N-1:0]    req_valid_i;
  logic [N-1:0]    req_ready_o;
  logic [32*N-1:0] req_data_i;
  logic [5*N-1:0]  req_shamt_i;
  logic [2*N-1:0]  req_op_i;
  logic            rsp_valid_o;
  logic            rsp_ready_i;
  logic [IDW-1:0]  rsp_id_o;
  logic [31:0]     rsp_data_o;
  logic            rsp_err_o;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int          m_ptr   = 0;
  logic        m_valid = 1'b0;
  int          m_id    = 0;
  logic [31:0] m_data  = '0;
  logic        m_err   = 1'b0;

  shift_arb #(.NUM_REQ(N)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_data_i  (req_data_i),
    .req_shamt_i (req_shamt_i),
    .req_op_i    (req_op_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_id_o    (rsp_id_o),
    .rsp_data_o  (rsp_data_o),
    .rsp_err_o   (rsp_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Shift result from arithmetic: multiply / divide by 2**s, floor for SRA.
  function automatic logic [31:0] ref_shift(logic [31:0] d, logic [4:0] s, logic [1:0] op);
    longint pw = 1;
    longint v;
    longint q;
    for (int i = 0; i < int'(s); i++) pw = pw * 2;
    case (op)
      2'd0: return 32'(longint'(d) * pw);
      2'd1: return 32'(longint'(d) / pw);
      2'd2: begin
        v = d[31] ? (longint'(d) - 64'sh1_0000_0000) : longint'(d);
        q = v / pw;
        if ((v % pw) != 0 && v < 0) q = q - 1;
        return 32'(q);
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_grant(logic [N-1:0] v, int p);
    for (int i = 0; i < N; i++) begin
      if (v[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic set_req(input int k, input logic [31:0] d, input logic [4:0] s, input logic [1:0] op);
    req_data_i[32*k +: 32] = d;
    req_shamt_i[5*k +: 5]  = s;
    req_op_i[2*k +: 2]     = op;
  endtask

  // One clock: starts just after a rising edge, checks ready before the edge
  // and the response register just after it.
  task automatic cycle(input logic [N-1:0] v, input logic rdy, output int acc);
    int g;
    logic [N-1:0] exp_rdy;
    req_valid_i = v;
    rsp_ready_i = rdy;
    #1;
    g   = ref_grant(v, m_ptr);
    acc = (g >= 0 && (!m_valid || rdy)) ? g : -1;
    exp_rdy = (acc >= 0) ? N'(1 << acc) : '0;
    chk("req_ready", 32'(req_ready_o), 32'(exp_rdy));
    @(posedge clk_i);
    if (acc >= 0) begin
      m_valid = 1'b1;
      m_id    = acc;
      m_data  = ref_shift(req_data_i[32*acc +: 32], req_shamt_i[5*acc +: 5], req_op_i[2*acc +: 2]);
      m_err   = (req_op_i[2*acc +: 2] == 2'b11);
      m_ptr   = (acc + 1) % N;
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    #1;
    chk("rsp_valid", 32'(rsp_valid_o), 32'(m_valid));
    if (m_valid) begin
      chk("rsp_id", 32'(rsp_id_o), 32'(m_id));
      chk("rsp_data", rsp_data_o, m_data);
      chk("rsp_err", 32'(rsp_err_o), 32'(m_err));
    end
  endtask

  initial begin
    int acc;
    logic [N-1:0] v;
    logic [1:0] rop;

    // Reset state with both requesters asking
    rst_ni      = 1'b0;
    req_valid_i = 2'b11;
    rsp_ready_i = 1'b1;
    req_data_i  = '0;
    req_shamt_i = '0;
    req_op_i    = '0;
    #1;
    chk("rst_ready", 32'(req_ready_o), 32'd0);
    chk("rst_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_id", 32'(rsp_id_o), 32'd0);
    chk("rst_data", rsp_data_o, 32'd0);
    chk("rst_err", 32'(rsp_err_o), 32'd0);
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_ni      = 1'b1;
    req_valid_i = '0;

    // Single SRA on requester 0
    set_req(0, 32'h8000_0001, 5'd1, 2'b10);
    cycle(2'b01, 1'b1, acc);
    chk("tp_sra_data", rsp_data_o, 32'hC000_0000);

    // Op sweep on requester 1
    set_req(1, 32'hF000_000F, 5'd4, 2'b00);
    cycle(2'b10, 1'b1, acc);
    chk("tp_sll", rsp_data_o, 32'h0000_00F0);
    set_req(1, 32'hF000_000F, 5'd4, 2'b01);
    cycle(2'b10, 1'b1, acc);
    chk("tp_srl", rsp_data_o, 32'h0F00_0000);
    set_req(1, 32'hF000_000F, 5'd31, 2'b10);
    cycle(2'b10, 1'b1, acc);
    chk("tp_sra31", rsp_data_o, 32'hFFFF_FFFF);
    set_req(1, 32'hF000_000F, 5'd0, 2'b01);
    cycle(2'b10, 1'b1, acc);
    chk("tp_srl0", rsp_data_o, 32'hF000_000F);
    set_req(1, 32'hF000_000F, 5'd3, 2'b11);
    cycle(2'b10, 1'b1, acc);
    chk("tp_ill_data", rsp_data_o, 32'd0);
    chk("tp_ill_err", 32'(rsp_err_o), 32'd1);

    // Both valid back-to-back: grants alternate 0,1,0,1
    set_req(0, 32'h1234_5678, 5'd8, 2'b00);
    set_req(1, 32'h8765_4321, 5'd8, 2'b10);
    for (int i = 0; i < 4; i++) begin
      cycle(2'b11, 1'b1, acc);
      chk("rr_id", 32'(rsp_id_o), 32'(i % 2));
    end

    // Backpressure for three cycles, then release
    for (int i = 0; i < 3; i++) cycle(2'b11, 1'b0, acc);
    cycle(2'b11, 1'b1, acc);

    // Fairness after idle
    cycle(2'b10, 1'b1, acc);
    cycle(2'b00, 1'b1, acc);
    cycle(2'b01, 1'b1, acc);
    chk("fair_req0", 32'(rsp_id_o), 32'd0);
    cycle(2'b11, 1'b1, acc);
    chk("fair_req1", 32'(rsp_id_o), 32'd1);

    // Random traffic honouring the hold-until-accepted rule
    v = '0;
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < N; k++) begin
        if (!v[k] && $urandom_range(0, 2) != 0) begin
          v[k] = 1'b1;
          rop  = 2'($urandom_range(0, 3));
          set_req(k, $urandom, 5'($urandom_range(0, 31)), rop);
        end
      end
      cycle(v, ($urandom_range(0, 3) != 0), acc);
      if (acc >= 0) v[acc] = 1'b0;
    end

    // Asynchronous reset while a response is held
    set_req(0, 32'h0000_00FF, 5'd2, 2'b00);
    set_req(1, 32'hFF00_0000, 5'd2, 2'b01);
    cycle(2'b11, 1'b1, acc);
    req_valid_i = 2'b11;
    rsp_ready_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    chk("mrst_valid", 32'(rsp_valid_o), 32'd0);
    chk("mrst_ready", 32'(req_ready_o), 32'd0);
    m_valid = 1'b0;
    m_ptr   = 0;
    @(negedge clk_i);
    req_valid_i = '0;
    rst_ni      = 1'b1;
    @(posedge clk_i); #1;
    cycle(2'b11, 1'b1, acc);
    chk("mrst_first", 32'(rsp_id_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
